conv_frame_sequencer: RTL and testbench

//  Frame-level controller for the binary convolution datapath. Collects an IMG_DIM x IMG_DIM

---
 rtl/conv_frame_sequencer.sv | 137 +++++++++++++
 tb/tb_conv_frame_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/conv_frame_sequencer.sv
// conv_frame_sequencer: loads one UART pixel frame, then steps the window engine over every output position and sends each result as a byte
module conv_frame_sequencer #(
  parameter int IMG_DIM    = 8,
  parameter int K_DIM      = 3,
  parameter int RES_W      = 4,
  parameter int RX_TIMEOUT = 100000
) (
  input  logic                                     clk,
  input  logic                                     sw_reset_n,
  input  logic                                     rx_valid,
  input  logic [7:0]                               rx_data,
  output logic                                     img_we,
  output logic [$clog2(IMG_DIM*IMG_DIM)-1:0]       img_waddr,
  output logic [7:0]                               img_wdata,
  output logic                                     conv_start,
  output logic [$clog2(IMG_DIM-K_DIM+1)-1:0]       conv_row,
  output logic [$clog2(IMG_DIM-K_DIM+1)-1:0]       conv_col,
  input  logic                                     conv_done,
  input  logic [RES_W-1:0]                         conv_result,
  output logic                                     tx_start,
  output logic [7:0]                               tx_data,
  input  logic                                     tx_busy,
  output logic                                     busy,
  output logic                                     frame_done,
  output logic                                     rx_timeout,
  output logic                                     overrun
);
  localparam int OUT_DIM = IMG_DIM - K_DIM + 1;
  localparam int NPIX    = IMG_DIM * IMG_DIM;
  localparam int AW      = $clog2(NPIX);
  localparam int OW      = $clog2(OUT_DIM);
  localparam int PW      = $clog2(NPIX + 1);
  localparam int TW      = $clog2(RX_TIMEOUT + 1);
  localparam logic [PW-1:0] LAST_PIX = PW'(NPIX - 1);
  localparam logic [OW-1:0] LAST_POS = OW'(OUT_DIM - 1);
  localparam logic [TW-1:0] TMAX     = TW'(RX_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, LOAD, C_ISSUE, C_WAIT, T_ISSUE, T_WAIT, DONE} state_t;

  state_t          state, nxt;
  logic [PW-1:0]   pix_cnt;
  logic [TW-1:0]   tcnt;
  logic [OW-1:0]   oi, oj;
  logic            guard;
  logic            last, accept, expire, advance;
  logic            we_d, cs_d, ts_d, busy_d, fd_d, to_d, ov_d;
  logic [AW-1:0]   waddr_d;
  logic [7:0]      wdata_d, txd_d;

  assign last    = (oi == LAST_POS) && (oj == LAST_POS);
  assign accept  = rx_valid && (state == IDLE || state == LOAD);
  assign expire  = (state == LOAD) && !rx_valid && (tcnt == TMAX);
  assign advance = (state == T_WAIT) && !guard && !tx_busy;

  // State and registered outputs; every output leaves reset at 0
  always_ff @(posedge clk or negedge sw_reset_n) begin
    if (!sw_reset_n) begin
      state      <= IDLE;
      img_we     <= 1'b0;
      img_waddr  <= '0;
      img_wdata  <= '0;
      conv_start <= 1'b0;
      conv_row   <= '0;
      conv_col   <= '0;
      tx_start   <= 1'b0;
      tx_data    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      rx_timeout <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= nxt;
      img_we     <= we_d;
      img_waddr  <= waddr_d;
      img_wdata  <= wdata_d;
      conv_start <= cs_d;
      conv_row   <= oi;
      conv_col   <= oj;
      tx_start   <= ts_d;
      tx_data    <= txd_d;
      busy       <= busy_d;
      frame_done <= fd_d;
      rx_timeout <= to_d;
      overrun    <= ov_d;
    end
  end

  // Next-state: a byte in LOAD always beats a timeout expiring in the same cycle
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = rx_valid ? LOAD : IDLE;
      LOAD:    nxt = (rx_valid && pix_cnt == LAST_PIX) ? C_ISSUE : (expire ? IDLE : LOAD);
      C_ISSUE: nxt = C_WAIT;
      C_WAIT:  nxt = conv_done ? T_ISSUE : C_WAIT;
      T_ISSUE: nxt = tx_busy ? T_ISSUE : T_WAIT;
      T_WAIT:  nxt = advance ? (last ? DONE : C_ISSUE) : T_WAIT;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Output next-values; address/data/tx_data hold when not being updated
  always_comb begin
    we_d    = accept;
    waddr_d = accept ? ((state == IDLE) ? '0 : AW'(pix_cnt)) : img_waddr;
    wdata_d = accept ? rx_data : img_wdata;
    cs_d    = state == C_ISSUE;
    ts_d    = (state == T_ISSUE) && !tx_busy;
    txd_d   = (state == C_WAIT && conv_done) ? 8'(conv_result) : tx_data;
    busy_d  = nxt != IDLE;
    fd_d    = state == DONE;
    to_d    = expire;
    ov_d    = overrun || (rx_valid && !accept);
  end

  // Pixel, timeout and output-position counters; guard marks the first T_WAIT cycle
  always_ff @(posedge clk or negedge sw_reset_n) begin
    if (!sw_reset_n) begin
      pix_cnt <= '0;
      tcnt    <= '0;
      oi      <= '0;
      oj      <= '0;
      guard   <= 1'b0;
    end else begin
      pix_cnt <= (state == IDLE && rx_valid) ? PW'(1) :
                 (state == LOAD && rx_valid) ? pix_cnt + 1'b1 :
                 expire ? '0 : pix_cnt;
      tcnt    <= (state == LOAD && !rx_valid && !expire) ? tcnt + 1'b1 : '0;
      guard   <= state == T_ISSUE;
      if (advance) begin
        oj <= (last || oj == LAST_POS) ? '0 : oj + 1'b1;
        oi <= last ? '0 : (oj == LAST_POS) ? oi + 1'b1 : oi;
      end
    end
  end
endmodule

// File: tb/tb_conv_frame_sequencer.sv
// tb_conv_frame_sequencer: directed frames against an engine/transmitter model with hand-computed expected bytes
module tb_conv_frame_sequencer;
  localparam int TMO = 200;

  logic       clk = 0;
  logic       sw_reset_n = 0;
  logic       rx_valid = 0;
  logic [7:0] rx_data = 0;
  logic       img_we;
  logic [5:0] img_waddr;
  logic [7:0] img_wdata;
  logic       conv_start;
  logic [2:0] conv_row, conv_col;
  logic       conv_done = 0;
  logic [3:0] conv_result = 0;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy = 0;
  logic       busy, frame_done, rx_timeout, overrun;

  conv_frame_sequencer #(.IMG_DIM(8), .K_DIM(3), .RES_W(4), .RX_TIMEOUT(TMO)) dut (
    .clk(clk), .sw_reset_n(sw_reset_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .img_we(img_we), .img_waddr(img_waddr), .img_wdata(img_wdata),
    .conv_start(conv_start), .conv_row(conv_row), .conv_col(conv_col),
    .conv_done(conv_done), .conv_result(conv_result),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .busy(busy), .frame_done(frame_done), .rx_timeout(rx_timeout), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int         n_tests = 0, n_fail = 0;
  int         n_done = 0, n_tmo = 0, n_bad = 0;
  int         eng_cnt = 0, tx_cnt = 0, hold_cnt = 0;
  bit         hold = 0, prev_busy = 0;
  logic [7:0] mem [64];
  logic [7:0] txq[$];
  logic [5:0] convq[$];
  logic [5:0] wq[$];

  function automatic logic [3:0] win(int r, int c);
    int s = 0;
    s += int'(mem[r*8+c][0]);
    s += int'(mem[r*8+c+2][0]);
    s += int'(mem[(r+1)*8+c+1][0]);
    s += int'(mem[(r+2)*8+c][0]);
    s += int'(mem[(r+2)*8+c+2][0]);
    return 4'(s);
  endfunction

  // Image buffer, window engine (result 2 cycles after conv_start) and transmitter (busy 8 cycles)
  initial begin
    forever begin
      @(posedge clk); #1;
      if (!sw_reset_n) begin
        eng_cnt = 0; tx_cnt = 0; hold_cnt = 0; conv_done = 0; tx_busy = 0; prev_busy = 0;
      end else begin
        prev_busy = tx_busy;
        tx_busy = (tx_cnt != 0) || (hold_cnt != 0);
        if (tx_cnt != 0) tx_cnt--;
        if (hold_cnt != 0) hold_cnt--;
        if (img_we) begin mem[img_waddr] = img_wdata; wq.push_back(img_waddr); end
        if (frame_done) n_done++;
        if (rx_timeout) n_tmo++;
        if (tx_start) begin
          if (prev_busy) n_bad++;
          txq.push_back(tx_data);
          tx_cnt = 8;
        end
        conv_done = 0;
        if (eng_cnt != 0) begin eng_cnt--; if (eng_cnt == 0) conv_done = 1; end
        if (conv_start) begin
          convq.push_back({conv_row, conv_col});
          conv_result = win(int'(conv_row), int'(conv_col));
          eng_cnt = 2;
          if (hold) hold_cnt = 500;
        end
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(int first, int n, bit cb);
    for (int p = first; p < first + n; p++) begin
      rx_valid = 1;
      rx_data = cb ? 8'(((p / 8) + (p % 8)) & 1) : 8'h01;
      tick();
    end
    rx_valid = 0;
  endtask

  task automatic wait_frame(string tag, int b_done, int budget);
    int i = 0;
    while (n_done == b_done && i < budget) begin tick(); i++; end
    tick(3);
    check({tag, "_frame_done"}, n_done - b_done, 1);
    check({tag, "_busy_after"}, busy, 0);
  endtask

  task automatic check_frame(string tag, int b_tx, int b_cv, bit cb);
    int bad_tx = 0, bad_cv = 0;
    check({tag, "_ntx"}, txq.size() - b_tx, 36);
    check({tag, "_nconv"}, convq.size() - b_cv, 36);
    for (int k = 0; k < 36; k++) begin
      logic [7:0] e;
      logic [5:0] pos;
      e = (cb && (((k / 6) + (k % 6)) & 1) == 0) ? 8'h00 : 8'h05;
      pos = {3'(k / 6), 3'(k % 6)};
      if (b_tx + k >= txq.size() || txq[b_tx + k] !== e) bad_tx++;
      if (b_cv + k >= convq.size() || convq[b_cv + k] !== pos) bad_cv++;
    end
    check({tag, "_bytes_wrong"}, bad_tx, 0);
    check({tag, "_order_wrong"}, bad_cv, 0);
  endtask

  task automatic check_waddr(string tag, int b_w);
    int bad = 0;
    check({tag, "_nwrites"}, wq.size() - b_w, 64);
    for (int k = 0; k < 64; k++)
      if (b_w + k >= wq.size() || wq[b_w + k] !== 6'(k)) bad++;
    check({tag, "_waddr_wrong"}, bad, 0);
  endtask

  initial begin
    int b_tx, b_cv, b_w, b_done, i;
    tick(3);
    check("rst_outs", {busy, img_we, conv_start, tx_start, frame_done, rx_timeout, overrun}, 0);
    check("rst_data", {img_waddr, img_wdata, conv_row, conv_col, tx_data}, 0);
    sw_reset_n = 1;
    tick(2);
    check("idle_busy", busy, 0);

    // 1: all-ones frame
    b_tx = txq.size(); b_cv = convq.size(); b_done = n_done;
    send(0, 64, 0);
    wait_frame("t1", b_done, 3000);
    check_frame("t1", b_tx, b_cv, 0);
    check("t1_overrun", overrun, 0);

    // 2: checkerboard, plus write address and window order
    b_tx = txq.size(); b_cv = convq.size(); b_w = wq.size(); b_done = n_done;
    send(0, 64, 1);
    wait_frame("t2", b_done, 3000);
    check_frame("t2", b_tx, b_cv, 1);
    check_waddr("t2", b_w);

    // 3: partial frame, byte clears the idle counter, then abort
    b_cv = convq.size();
    send(0, 10, 0);
    tick(150);
    check("t3_no_tmo_early", n_tmo, 0);
    check("t3_busy_load", busy, 1);
    send(10, 1, 0);
    tick(150);
    check("t3_tmo_cleared", n_tmo, 0);
    tick(60);
    check("t3_tmo_pulse", n_tmo, 1);
    check("t3_idle", busy, 0);
    check("t3_no_conv", convq.size() - b_cv, 0);
    b_tx = txq.size(); b_cv = convq.size(); b_w = wq.size(); b_done = n_done;
    send(0, 64, 0);
    wait_frame("t3b", b_done, 3000);
    check_waddr("t3b", b_w);
    check_frame("t3b", b_tx, b_cv, 0);

    // 4: transmitter held busy 500 cycles before each result
    hold = 1;
    b_tx = txq.size(); b_cv = convq.size(); b_done = n_done;
    send(0, 64, 0);
    wait_frame("t4", b_done, 40000);
    check_frame("t4", b_tx, b_cv, 0);
    check("t4_start_while_busy", n_bad, 0);
    hold = 0;

    // 5: byte arriving in C_WAIT sets sticky overrun only
    b_tx = txq.size(); b_cv = convq.size(); b_done = n_done;
    send(0, 64, 1);
    i = 0;
    while (!conv_start && i < 100) begin tick(); i++; end
    check("t5_conv_start_seen", conv_start, 1);
    tick();
    rx_valid = 1; rx_data = 8'hAA;
    tick();
    rx_valid = 0;
    check("t5_overrun_set", overrun, 1);
    wait_frame("t5", b_done, 3000);
    check_frame("t5", b_tx, b_cv, 1);
    check("t5_overrun_sticky", overrun, 1);

    // 6: asynchronous reset during T_WAIT of result 20
    b_tx = txq.size();
    send(0, 64, 0);
    i = 0;
    while (txq.size() - b_tx < 20 && i < 3000) begin tick(); i++; end
    check("t6_reached_20", txq.size() - b_tx, 20);
    tick(2);
    #3 sw_reset_n = 0;
    #1;
    check("t6_rst_outs", {busy, img_we, conv_start, tx_start, frame_done, rx_timeout, overrun}, 0);
    check("t6_rst_data", {img_waddr, img_wdata, conv_row, conv_col, tx_data}, 0);
    tick(3);
    sw_reset_n = 1;
    tick(2);
    b_tx = txq.size(); b_cv = convq.size(); b_w = wq.size(); b_done = n_done;
    send(0, 64, 0);
    wait_frame("t6", b_done, 3000);
    check_frame("t6", b_tx, b_cv, 0);
    check_waddr("t6", b_w);
    check("all_start_while_busy", n_bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
